// File: rtl/gate_cursor_ctrl_pkg.sv
// Shared definitions for the gate-select cursor: grid limits, direction and FSM
// encodings, and the navigation function that maps (cell, direction) to the next cell.
package gate_cursor_ctrl_pkg;

  localparam int GATE_W = 5;
  localparam logic [GATE_W-1:0] GATE_MIN = 5'd1;
  localparam logic [GATE_W-1:0] GATE_ROW = 5'd8;
  localparam logic [GATE_W-1:0] GATE_MAX = 5'd18;

  typedef enum logic [1:0] {
    DIR_U = 2'd0,
    DIR_D = 2'd1,
    DIR_L = 2'd2,
    DIR_R = 2'd3
  } dir_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MOVE = 2'd1,
    ST_LOCK = 2'd2
  } state_e;

  // Rows: A = 1..8, B = 9..16, C = 17..18. Horizontal moves wrap inside a row.
  // Any illegal current cell (0 or above GATE_MAX) recovers to GATE_MIN.
  function automatic logic [GATE_W-1:0] nav_next(input logic [GATE_W-1:0] cur,
                                                 input dir_e dir);
    logic [GATE_W-1:0] nxt;
    nxt = cur;
    if (cur < GATE_MIN || cur > GATE_MAX) begin
      nxt = GATE_MIN;
    end else begin
      case (dir)
        DIR_R: begin
          if (cur == 5'd8)       nxt = 5'd1;
          else if (cur == 5'd16) nxt = 5'd9;
          else if (cur == 5'd18) nxt = 5'd17;
          else                   nxt = cur + 5'd1;
        end
        DIR_L: begin
          if (cur == 5'd1)       nxt = 5'd8;
          else if (cur == 5'd9)  nxt = 5'd16;
          else if (cur == 5'd17) nxt = 5'd18;
          else                   nxt = cur - 5'd1;
        end
        DIR_U: begin
          if (cur == 5'd17)      nxt = 5'd10;
          else if (cur == 5'd18) nxt = 5'd15;
          else if (cur > GATE_ROW) nxt = cur - GATE_ROW;
          else                   nxt = cur;
        end
        default: begin
          if (cur >= 5'd9 && cur <= 5'd12)       nxt = 5'd17;
          else if (cur >= 5'd13 && cur <= 5'd16) nxt = 5'd18;
          else if (cur <= GATE_ROW)              nxt = cur + GATE_ROW;
          else                                   nxt = cur;
        end
      endcase
    end
    return nxt;
  endfunction

endpackage

// File: rtl/gate_cursor_ctrl_btn_debounce.sv
// One button input: 2-FF synchroniser, stability counter, and a one-clock pulse
// on each rising edge of the debounced level.
module btn_debounce #(
  parameter int DEBOUNCE_CYCLES = 1_000_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw,
  output logic level,
  output logic rise
);

  localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync1_q, sync2_q;
  logic             level_q, level_d;
  logic             rise_q, rise_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // The counter only runs while the synced input disagrees with the level, so a
  // change must persist for DEBOUNCE_CYCLES consecutive clocks to be accepted.
  always_comb begin
    cnt_d   = '0;
    level_d = level_q;
    if (sync2_q != level_q) begin
      if (cnt_q == CNT_LAST) begin
        level_d = sync2_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
    rise_d = level_d & ~level_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      level_q <= 1'b0;
      rise_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= raw;
      sync2_q <= sync1_q;
      level_q <= level_d;
      rise_q  <= rise_d;
      cnt_q   <= cnt_d;
    end
  end

  assign level = level_q;
  assign rise  = rise_q;

endmodule

// File: rtl/gate_cursor_ctrl.sv
// Button-driven cursor for the VGA gate-select grid: four debounced buttons feed a
// priority encoder and an IDLE/MOVE/LOCK FSM that moves gate_select one cell per press.
module gate_cursor_ctrl
  import gate_cursor_ctrl_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 1_000_000,
  parameter int SEL_W           = 5
) (
  input  logic             CLK100MHZ,
  input  logic             CPU_RESETN,
  input  logic             en,
  input  logic             BTNU,
  input  logic             BTND,
  input  logic             BTNL,
  input  logic             BTNR,
  output logic [SEL_W-1:0] gate_select,
  output logic             moved,
  output logic [1:0]       move_dir,
  output state_e           state_dbg
);

  logic [3:0] raw_btn, level, rise;

  // Vector index equals the dir_e encoding.
  assign raw_btn = {BTNR, BTNL, BTND, BTNU};

  for (genvar i = 0; i < 4; i++) begin : g_btn
    btn_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_btn (
      .clk  (CLK100MHZ),
      .rst_n(CPU_RESETN),
      .raw  (raw_btn[i]),
      .level(level[i]),
      .rise (rise[i])
    );
  end

  state_e           state_q, state_d;
  dir_e             dir_q, dir_d;
  dir_e             move_dir_q, move_dir_d;
  logic [SEL_W-1:0] gate_select_q, gate_select_d;
  logic             moved_q, moved_d;
  dir_e             press_dir;
  logic [GATE_W-1:0] cur_cell;

  always_comb begin
    if (rise[0])      press_dir = DIR_U;
    else if (rise[1]) press_dir = DIR_D;
    else if (rise[2]) press_dir = DIR_L;
    else              press_dir = DIR_R;
  end

  // Upper bits beyond the grid width make the value illegal; present 0 so nav_next recovers it.
  assign cur_cell = (gate_select_q > SEL_W'(GATE_MAX)) ? '0 : gate_select_q[GATE_W-1:0];

  always_comb begin
    state_d       = state_q;
    dir_d         = dir_q;
    move_dir_d    = move_dir_q;
    gate_select_d = gate_select_q;
    moved_d       = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (en && (|rise)) begin
          dir_d   = press_dir;
          state_d = ST_MOVE;
        end
      end
      ST_MOVE: begin
        gate_select_d = SEL_W'(nav_next(cur_cell, dir_q));
        move_dir_d    = dir_q;
        moved_d       = 1'b1;
        state_d       = ST_LOCK;
      end
      ST_LOCK: begin
        if (level == 4'b0000) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
    if (!CPU_RESETN) begin
      state_q       <= ST_IDLE;
      dir_q         <= DIR_U;
      move_dir_q    <= DIR_U;
      gate_select_q <= SEL_W'(GATE_MIN);
      moved_q       <= 1'b0;
    end else begin
      state_q       <= state_d;
      dir_q         <= dir_d;
      move_dir_q    <= move_dir_d;
      gate_select_q <= gate_select_d;
      moved_q       <= moved_d;
    end
  end

  assign gate_select = gate_select_q;
  assign moved       = moved_q;
  assign move_dir    = move_dir_q;
  assign state_dbg   = state_q;

endmodule

// File: tb/tb_gate_cursor_ctrl.sv
// Directed bench for gate_cursor_ctrl with a short debounce window; expected cells
// are hand-computed from the navigation table and queued ahead of each press.
module tb_gate_cursor_ctrl;
  import gate_cursor_ctrl_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       en;
  logic       btn_u, btn_d, btn_l, btn_r;
  logic [4:0] gate_select;
  logic       moved;
  logic [1:0] move_dir;
  state_e     state_dbg;

  int n_cmp = 0;
  int n_bad = 0;
  logic [4:0] exp_q[$];

  gate_cursor_ctrl #(
    .DEBOUNCE_CYCLES(4),
    .SEL_W(5)
  ) dut (
    .CLK100MHZ  (clk),
    .CPU_RESETN (rst_n),
    .en         (en),
    .BTNU       (btn_u),
    .BTND       (btn_d),
    .BTNL       (btn_l),
    .BTNR       (btn_r),
    .gate_select(gate_select),
    .moved      (moved),
    .move_dir   (move_dir),
    .state_dbg  (state_dbg)
  );

  // Clock / reset
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic set_btn(input int b, input logic v);
    case (b)
      0: btn_u = v;
      1: btn_d = v;
      2: btn_l = v;
      default: btn_r = v;
    endcase
  endtask

  // Advance n cycles, adding every observed moved pulse to pulses.
  task automatic run_cycles(input int n, inout int pulses);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (moved) pulses++;
    end
  endtask

  // One full press gesture; expected cell comes from the scoreboard queue.
  task automatic press(input string tag, input int b, input logic [1:0] exp_dir);
    logic [4:0] exp_sel;
    logic [4:0] sel_seen;
    logic [1:0] dir_seen;
    int pulses, t_move, t_moved;
    exp_sel  = exp_q.pop_front();
    sel_seen = '0;
    dir_seen = '0;
    pulses   = 0;
    t_move   = -1;
    t_moved  = -1;
    set_btn(b, 1'b1);
    for (int i = 0; i < 70; i++) begin
      @(negedge clk);
      if (state_dbg == ST_MOVE && t_move < 0) t_move = i;
      if (moved) begin
        pulses++;
        if (t_moved < 0) begin
          t_moved  = i;
          sel_seen = gate_select;
          dir_seen = move_dir;
        end
      end
      if (i == 39) set_btn(b, 1'b0);
    end
    check({tag, "_pulses"}, pulses, 1);
    check({tag, "_sel"}, sel_seen, exp_sel);
    check({tag, "_dir"}, dir_seen, exp_dir);
    check({tag, "_latency"}, t_moved - t_move, 1);
    check({tag, "_hold"}, gate_select, exp_sel);
    check({tag, "_idle"}, 32'(state_dbg), 32'(ST_IDLE));
  endtask

  initial begin
    int pulses;
    int waited;
    rst_n = 1'b0;
    en    = 1'b1;
    btn_u = 1'b0;
    btn_d = 1'b0;
    btn_l = 1'b0;
    btn_r = 1'b0;

    // Reset values, then release with no buttons
    repeat (3) @(negedge clk);
    check("rst_sel", gate_select, 1);
    check("rst_moved", moved, 0);
    check("rst_dir", move_dir, 0);
    check("rst_state", 32'(state_dbg), 32'(ST_IDLE));
    rst_n = 1'b1;
    pulses = 0;
    run_cycles(10, pulses);
    check("post_rst_pulses", pulses, 0);
    check("post_rst_sel", gate_select, 1);

    exp_q.push_back(5'd2);
    press("r_1_2", 3, 2'd3);

    // Asynchronous reset while LOCK holds the freshly moved cell
    set_btn(3, 1'b1);
    waited = 0;
    while (state_dbg != ST_LOCK && waited < 40) begin
      @(negedge clk);
      waited++;
    end
    check("reach_lock", 32'(state_dbg), 32'(ST_LOCK));
    check("pre_rst_sel", gate_select, 3);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_sel", gate_select, 1);
    check("async_rst_moved", moved, 0);
    check("async_rst_state", 32'(state_dbg), 32'(ST_IDLE));
    set_btn(3, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    pulses = 0;
    run_cycles(20, pulses);
    check("rst_hold_pulses", pulses, 0);
    check("rst_hold_sel", gate_select, 1);

    // Horizontal wrap across row A, then rows B and C
    for (int k = 0; k < 8; k++) exp_q.push_back((k == 7) ? 5'd1 : 5'(k + 2));
    for (int k = 0; k < 8; k++) press("wrap_r", 3, 2'd3);
    exp_q.push_back(5'd9);  press("d_1_9", 1, 2'd1);
    exp_q.push_back(5'd16); press("l_9_16", 2, 2'd2);
    exp_q.push_back(5'd18); press("d_16_18", 1, 2'd1);
    exp_q.push_back(5'd17); press("r_18_17", 3, 2'd3);

    // Vertical moves
    exp_q.push_back(5'd10); press("u_17_10", 0, 2'd0);
    exp_q.push_back(5'd2);  press("u_10_2", 0, 2'd0);
    exp_q.push_back(5'd3);  press("r_2_3", 3, 2'd3);
    exp_q.push_back(5'd11); press("d_3_11", 1, 2'd1);
    exp_q.push_back(5'd17); press("d_11_17", 1, 2'd1);
    exp_q.push_back(5'd10); press("u_17_10b", 0, 2'd0);
    exp_q.push_back(5'd2);  press("u_10_2b", 0, 2'd0);
    exp_q.push_back(5'd2);  press("u_2_noop", 0, 2'd0);

    // Bouncing contact settles into exactly one move
    pulses = 0;
    for (int i = 0; i < 20; i++) begin
      set_btn(3, ((i / 2) % 2) == 0);
      run_cycles(1, pulses);
    end
    set_btn(3, 1'b1);
    run_cycles(30, pulses);
    set_btn(3, 1'b0);
    run_cycles(30, pulses);
    check("bounce_pulses", pulses, 1);
    check("bounce_sel", gate_select, 3);
    check("bounce_dir", move_dir, 3);

    // Glitch shorter than the debounce window
    pulses = 0;
    set_btn(3, 1'b1);
    run_cycles(3, pulses);
    set_btn(3, 1'b0);
    run_cycles(30, pulses);
    check("glitch_pulses", pulses, 0);
    check("glitch_sel", gate_select, 3);

    // Chord: U beats R, holding R afterwards gives nothing more
    exp_q.push_back(5'd11); press("d_3_11b", 1, 2'd1);
    exp_q.push_back(5'd12); press("r_11_12", 3, 2'd3);
    pulses = 0;
    btn_u = 1'b1;
    btn_r = 1'b1;
    run_cycles(30, pulses);
    btn_u = 1'b0;
    run_cycles(100, pulses);
    check("chord_hold_state", 32'(state_dbg), 32'(ST_LOCK));
    btn_r = 1'b0;
    run_cycles(30, pulses);
    check("chord_pulses", pulses, 1);
    check("chord_sel", gate_select, 4);
    check("chord_dir", move_dir, 0);
    check("chord_idle", 32'(state_dbg), 32'(ST_IDLE));

    // Enable gating
    exp_q.push_back(5'd5); press("r_4_5", 3, 2'd3);
    en = 1'b0;
    pulses = 0;
    set_btn(1, 1'b1);
    run_cycles(30, pulses);
    set_btn(1, 1'b0);
    run_cycles(30, pulses);
    check("en0_pulses", pulses, 0);
    check("en0_sel", gate_select, 5);
    check("en0_state", 32'(state_dbg), 32'(ST_IDLE));
    en = 1'b1;
    exp_q.push_back(5'd13); press("d_5_13", 1, 2'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
